// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode constants, field positions and FSM state encoding
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ISSUE = 2'b10
    } fetch_state_e;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [INSTR_W-1:0] ir);
        return {{14{ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection (jump > taken branch > sequential)
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               alu_zero,
    output logic [31:0]        next_pc
);

    logic [5:0] unused_opcode;

    assign unused_opcode = instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
        end else if (Branch && alu_zero) begin
            next_pc = pc_plus4 + branch_offset(instr);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - FETCH/WAIT/ISSUE sequencer holding the IR until the datapath releases it
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               alu_zero,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fetch_err
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;

    // Strobes are masked while reset is held so the bus stays quiet during reset.
    assign imem_req    = (state == ST_FETCH) && !reset;
    assign instr_valid = (state == ST_ISSUE) && !reset;
    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .Branch   (Branch),
        .Jump     (Jump),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            instr     <= '0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            // A response arriving when nothing is outstanding is dropped and flagged.
            if (imem_rvalid && (state != ST_WAIT)) begin
                fetch_err <= 1'b1;
            end
            case (state)
                ST_FETCH: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        state <= ST_ISSUE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fetch_err <= 1'b1;
                        state     <= ST_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        pc    <= next_pc;
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
